// File: rtl/echo_arbiter.sv
// echo_arbiter
// Shares one sound channel between a live request stream and a delayed echo
// stream. Live note-on events take the channel immediately. Echo events are
// buffered in a 4-entry FIFO and replayed only while live is idle, with at
// least GAP_CYCLES cycles between successive replays.
//
// Ports
//   clk, reset              rising-edge clock, synchronous active-high reset
//   en                      clock enable; low holds everything, pulses read 0
//   live_on/note/vel/pb     live request tuple (1/7/7/9 bits)
//   echo_on/note/vel/pb     delayed echo tuple (1/7/7/9 bits)
//   ch_on/note/vel/pb       tuple driven to the shared channel (registered)
//   ch_trig                 one-cycle pulse when a new tuple is driven
//   owner                   0 = live owns the channel, 1 = echo owns it
//   echo_drop               one-cycle pulse when an echo is lost (queue full)
//   q_count                 echo queue occupancy, 0..4
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | channel free; a live note-on wins, otherwise pop a queued echo
// LIVE  | live owns the channel until a live note-off is driven
// GAP   | echo just replayed; spacing counter runs, live note-on preempts

module echo_arbiter #(
    parameter int GAP_CYCLES = 16,
    parameter int QDEPTH     = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       live_on,
    input  logic [6:0] live_note,
    input  logic [6:0] live_vel,
    input  logic [8:0] live_pb,
    input  logic       echo_on,
    input  logic [6:0] echo_note,
    input  logic [6:0] echo_vel,
    input  logic [8:0] echo_pb,
    output logic       ch_on,
    output logic [6:0] ch_note,
    output logic [6:0] ch_vel,
    output logic [8:0] ch_pb,
    output logic       ch_trig,
    output logic       owner,
    output logic       echo_drop,
    output logic [2:0] q_count
);

    typedef enum logic [1:0] {S_IDLE, S_LIVE, S_GAP} state_t;

    localparam logic [7:0] GAP_LAST = 8'(GAP_CYCLES - 1);
    localparam logic [2:0] Q_FULL   = 3'(QDEPTH);

    state_t      state;
    logic [7:0]  gap_cnt;
    logic [23:0] live_prev;
    logic [23:0] echo_prev;
    logic [23:0] mem [0:3];
    logic [1:0]  wr_ptr;
    logic [1:0]  rd_ptr;
    logic        trig_q;
    logic        drop_q;

    logic [23:0] live_tup;
    logic [23:0] echo_tup;
    logic        live_evt;
    logic        live_start;
    logic        echo_evt;
    logic        pop;
    logic        drop;
    logic        do_push;

    assign live_tup   = {live_on, live_note, live_vel, live_pb};
    assign echo_tup   = {echo_on, echo_note, echo_vel, echo_pb};
    assign live_evt   = (live_tup != live_prev);
    assign live_start = live_evt && live_on;
    assign echo_evt   = (echo_tup != echo_prev);

    // Pop only from IDLE and only when live is not claiming the channel.
    assign pop     = (state == S_IDLE) && !live_start && (q_count != 3'd0);
    // A simultaneous pop frees a slot, so a full queue only drops without one.
    assign drop    = echo_evt && (q_count == Q_FULL) && !pop;
    assign do_push = echo_evt && !drop;

    // Pulses are gated by en so they read 0 for the whole disabled cycle.
    assign ch_trig   = trig_q & en;
    assign echo_drop = drop_q & en;

    // Queue storage needs no reset: the pointers and count define validity.
    always_ff @(posedge clk) begin
        if (!reset && en && do_push) begin
            mem[wr_ptr] <= echo_tup;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            gap_cnt   <= 8'd0;
            live_prev <= 24'd0;
            echo_prev <= 24'd0;
            wr_ptr    <= 2'd0;
            rd_ptr    <= 2'd0;
            q_count   <= 3'd0;
            ch_on     <= 1'b0;
            ch_note   <= 7'd0;
            ch_vel    <= 7'd0;
            ch_pb     <= 9'd0;
            owner     <= 1'b0;
            trig_q    <= 1'b0;
            drop_q    <= 1'b0;
        end else if (!en) begin
            trig_q <= 1'b0;
            drop_q <= 1'b0;
        end else begin
            live_prev <= live_tup;
            echo_prev <= echo_tup;
            trig_q    <= 1'b0;
            drop_q    <= drop;

            if (do_push) begin
                wr_ptr <= wr_ptr + 2'd1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 2'd1;
            end
            q_count <= q_count + {2'd0, do_push} - {2'd0, pop};

            case (state)
                S_IDLE: begin
                    if (live_start) begin
                        {ch_on, ch_note, ch_vel, ch_pb} <= live_tup;
                        trig_q <= 1'b1;
                        owner  <= 1'b0;
                        state  <= S_LIVE;
                    end else if (pop) begin
                        {ch_on, ch_note, ch_vel, ch_pb} <= mem[rd_ptr];
                        trig_q  <= 1'b1;
                        owner   <= 1'b1;
                        gap_cnt <= 8'd0;
                        state   <= S_GAP;
                    end
                end
                S_LIVE: begin
                    if (live_evt) begin
                        {ch_on, ch_note, ch_vel, ch_pb} <= live_tup;
                        trig_q <= 1'b1;
                        if (!live_on) begin
                            state <= S_IDLE;
                        end
                    end
                end
                S_GAP: begin
                    if (live_start) begin
                        {ch_on, ch_note, ch_vel, ch_pb} <= live_tup;
                        trig_q  <= 1'b1;
                        owner   <= 1'b0;
                        gap_cnt <= 8'd0;
                        state   <= S_LIVE;
                    end else if (gap_cnt == GAP_LAST) begin
                        gap_cnt <= 8'd0;
                        state   <= S_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 8'd1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_echo_arbiter.sv
// tb_echo_arbiter
// Directed bench for echo_arbiter. Expected channel tuples go into a live or
// echo scoreboard queue when stimulus is applied and are popped and compared
// whenever the DUT pulses ch_trig (owner selects the queue).

module tb_echo_arbiter;

    localparam int GAP = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic       live_on;
    logic [6:0] live_note;
    logic [6:0] live_vel;
    logic [8:0] live_pb;
    logic       echo_on;
    logic [6:0] echo_note;
    logic [6:0] echo_vel;
    logic [8:0] echo_pb;
    logic       ch_on;
    logic [6:0] ch_note;
    logic [6:0] ch_vel;
    logic [8:0] ch_pb;
    logic       ch_trig;
    logic       owner;
    logic       echo_drop;
    logic [2:0] q_count;

    int errors = 0;
    int checks = 0;

    logic [23:0] live_q[$];
    logic [23:0] echo_q[$];

    always #5 clk = ~clk;

    echo_arbiter #(.GAP_CYCLES(GAP), .QDEPTH(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .live_on   (live_on),
        .live_note (live_note),
        .live_vel  (live_vel),
        .live_pb   (live_pb),
        .echo_on   (echo_on),
        .echo_note (echo_note),
        .echo_vel  (echo_vel),
        .echo_pb   (echo_pb),
        .ch_on     (ch_on),
        .ch_note   (ch_note),
        .ch_vel    (ch_vel),
        .ch_pb     (ch_pb),
        .ch_trig   (ch_trig),
        .owner     (owner),
        .echo_drop (echo_drop),
        .q_count   (q_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // Advance one cycle and sample at the falling edge; consume a scoreboard
    // entry whenever the DUT announces a new tuple.
    task automatic step();
        logic [23:0] got;
        @(posedge clk);
        @(negedge clk);
        if (ch_trig === 1'b1) begin
            got = {ch_on, ch_note, ch_vel, ch_pb};
            if (owner === 1'b0) begin
                if (live_q.size() == 0) chk("unexpected_live_trig", {31'd0, ch_trig}, 32'd0);
                else                    chk("live_tuple", {8'd0, got}, {8'd0, live_q.pop_front()});
            end else begin
                if (echo_q.size() == 0) chk("unexpected_echo_trig", {31'd0, ch_trig}, 32'd0);
                else                    chk("echo_tuple", {8'd0, got}, {8'd0, echo_q.pop_front()});
            end
        end
    endtask

    task automatic wait_trig(input string tag, input int max_cycles, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (ch_trig !== 1'b1 && n < max_cycles);
        if (ch_trig !== 1'b1) chk({"timeout_", tag}, {31'd0, ch_trig}, 32'd1);
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic set_live(input logic on, input logic [6:0] note, input logic [6:0] vel,
                            input logic [8:0] pb, input bit expect_out);
        live_on = on; live_note = note; live_vel = vel; live_pb = pb;
        if (expect_out) live_q.push_back({on, note, vel, pb});
    endtask

    task automatic set_echo(input logic on, input logic [6:0] note, input logic [6:0] vel,
                            input logic [8:0] pb, input bit expect_out);
        echo_on = on; echo_note = note; echo_vel = vel; echo_pb = pb;
        if (expect_out) echo_q.push_back({on, note, vel, pb});
    endtask

    initial begin
        int n;
        reset = 1'b1;
        en    = 1'b1;
        set_live(0, 0, 0, 0, 0);
        set_echo(0, 0, 0, 0, 0);
        steps(2);
        chk("rst_ch", {8'd0, ch_on, ch_note, ch_vel, ch_pb}, 32'd0);
        chk("rst_trig", {31'd0, ch_trig}, 32'd0);
        chk("rst_owner", {31'd0, owner}, 32'd0);
        chk("rst_drop", {31'd0, echo_drop}, 32'd0);
        chk("rst_qcount", {29'd0, q_count}, 32'd0);
        reset = 1'b0;
        step();
        chk("idle_no_trig", {31'd0, ch_trig}, 32'd0);

        // Live note-on from IDLE appears one edge later.
        set_live(1, 60, 100, 256, 1);
        step();
        chk("live_on_trig", {31'd0, ch_trig}, 32'd1);
        chk("live_on_owner", {31'd0, owner}, 32'd0);

        // Two echoes queued in LIVE, then live note-off, then paced replay.
        set_echo(1, 60, 50, 0, 1);
        step();
        chk("echo1_no_trig", {31'd0, ch_trig}, 32'd0);
        chk("echo1_q", {29'd0, q_count}, 32'd1);
        set_echo(0, 60, 50, 0, 1);
        step();
        chk("echo2_q", {29'd0, q_count}, 32'd2);
        chk("echo2_ch_hold", {31'd0, ch_on}, 32'd1);
        set_live(0, 60, 100, 256, 1);
        step();
        chk("live_off_trig", {31'd0, ch_trig}, 32'd1);
        chk("live_off_ch_on", {31'd0, ch_on}, 32'd0);
        step();
        chk("pop1_trig", {31'd0, ch_trig}, 32'd1);
        chk("pop1_owner", {31'd0, owner}, 32'd1);
        chk("pop1_q", {29'd0, q_count}, 32'd1);
        wait_trig("pop2", 40, n);
        chk("gap_spacing", {31'd0, (n >= GAP && n <= GAP + 1)}, 32'd1);
        chk("pop2_owner", {31'd0, owner}, 32'd1);
        chk("pop2_q", {29'd0, q_count}, 32'd0);
        steps(GAP + 4);

        // Five echoes in LIVE: fifth dropped, first four drain in order.
        set_live(1, 61, 90, 0, 1);
        step();
        chk("live2_trig", {31'd0, ch_trig}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            set_echo(1, 7'(62 + i), 40, 9'(i), (i < 4));
            step();
            chk("fill_q", {29'd0, q_count}, (i < 4) ? i + 1 : 4);
            chk("fill_drop", {31'd0, echo_drop}, (i == 4) ? 32'd1 : 32'd0);
        end
        set_live(0, 61, 90, 0, 1);
        step();
        chk("live2_off_trig", {31'd0, ch_trig}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            wait_trig("drain", 40, n);
            chk("drain_owner", {31'd0, owner}, 32'd1);
        end
        chk("drain_q", {29'd0, q_count}, 32'd0);
        steps(GAP + 4);

        // Live preempts GAP at counter 5; the queued echo is left alone.
        set_echo(1, 30, 31, 32, 1);
        step();
        chk("pre_q1", {29'd0, q_count}, 32'd1);
        set_echo(1, 33, 34, 35, 1);
        step();
        chk("pre_pop_trig", {31'd0, ch_trig}, 32'd1);
        chk("pre_pop_q", {29'd0, q_count}, 32'd1);
        steps(5);
        set_live(1, 72, 80, 0, 1);
        step();
        chk("preempt_trig", {31'd0, ch_trig}, 32'd1);
        chk("preempt_owner", {31'd0, owner}, 32'd0);
        chk("preempt_note", {25'd0, ch_note}, 32'd72);
        chk("preempt_q", {29'd0, q_count}, 32'd1);
        set_live(0, 72, 80, 0, 1);
        step();
        step();
        chk("after_preempt_pop", {31'd0, owner}, 32'd1);
        steps(GAP + 4);

        // Full queue in IDLE with an echo arriving on the pop cycle.
        set_live(1, 50, 50, 50, 1);
        step();
        for (int i = 0; i < 4; i++) begin
            set_echo(1, 7'(10 + i), 11, 12, 1);
            step();
        end
        chk("full_q", {29'd0, q_count}, 32'd4);
        set_live(0, 50, 50, 50, 1);
        step();
        set_echo(1, 20, 21, 22, 1);
        step();
        chk("pushpop_trig", {31'd0, ch_trig}, 32'd1);
        chk("pushpop_q", {29'd0, q_count}, 32'd4);
        chk("pushpop_drop", {31'd0, echo_drop}, 32'd0);
        for (int i = 0; i < 4; i++) wait_trig("drain_full", 40, n);
        chk("drain_full_q", {29'd0, q_count}, 32'd0);
        steps(GAP + 4);

        // Changes during en=0 are held and picked up on re-enable.
        set_live(1, 60, 100, 0, 1);
        step();
        en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (i == 3) set_live(1, 64, 100, 0, 0);
            step();
            chk("en0_trig", {31'd0, ch_trig}, 32'd0);
            chk("en0_note", {25'd0, ch_note}, 32'd60);
        end
        live_q.push_back({1'b1, 7'd64, 7'd100, 9'd0});
        en = 1'b1;
        step();
        chk("en1_trig", {31'd0, ch_trig}, 32'd1);
        chk("en1_note", {25'd0, ch_note}, 32'd64);

        // Reset mid-operation loses the queue; held inputs re-trigger after.
        set_echo(1, 5, 6, 7, 0);
        step();
        chk("mid_q", {29'd0, q_count}, 32'd1);
        reset = 1'b1;
        step();
        chk("mid_rst_q", {29'd0, q_count}, 32'd0);
        chk("mid_rst_ch", {8'd0, ch_on, ch_note, ch_vel, ch_pb}, 32'd0);
        chk("mid_rst_owner", {31'd0, owner}, 32'd0);
        step();
        reset = 1'b0;
        live_q.push_back({1'b1, 7'd64, 7'd100, 9'd0});
        echo_q.push_back({1'b1, 7'd5, 7'd6, 9'd7});
        step();
        chk("post_rst_trig", {31'd0, ch_trig}, 32'd1);
        chk("post_rst_q", {29'd0, q_count}, 32'd1);
        set_live(0, 64, 100, 0, 1);
        step();
        step();
        chk("post_rst_pop", {31'd0, owner}, 32'd1);
        chk("scoreboard_empty", live_q.size() + echo_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/echo_arbiter.md
ECHO_ARBITER -- requirements
Module: echo_arbiter

Interface
REQ-001 Parameter: GAP_CYCLES, default 16, minimum spacing in clk cycles between successive echo events driven from the queue (range 2..255).
REQ-002 Parameter: QDEPTH, fixed 4, echo queue entries.
REQ-003 clk  input  1  system clock; all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 en  input  1  clock enable; when low all state and outputs hold, ch_trig and echo_drop forced 0.
REQ-006 live_on / live_note / live_vel / live_pb  input  1/7/7/9  live channel request tuple.
REQ-007 echo_on / echo_note / echo_vel / echo_pb  input  1/7/7/9  delayed echo tuple from echo generator.
REQ-008 ch_on / ch_note / ch_vel / ch_pb  output  1/7/7/9  tuple driven to the shared sound channel.
REQ-009 ch_trig  output  1  one-cycle pulse when a new tuple is driven.
REQ-010 owner  output  1  0 = live owns channel, 1 = echo owns channel.
REQ-011 echo_drop  output  1  one-cycle pulse when an echo event is discarded (queue full).
REQ-012 q_count  output  3  current queue occupancy, 0..4.

Function
REQ-013 Live event: any field of the live tuple differs from its registered previous copy; the copy updates on every en cycle.
REQ-014 Echo event: same change detection on the echo tuple, independent registers.
REQ-015 Changes while en=0 are detected on the first cycle en=1.
REQ-016 States: IDLE, LIVE, GAP; one-hot or binary, implementer's choice.
REQ-017 IDLE: live event with live_on=1 -> drive live tuple, ch_trig=1, owner=0, go LIVE.
REQ-018 IDLE: no qualifying live event and q_count>0 -> pop head, drive it, ch_trig=1, owner=1, go GAP.
REQ-019 IDLE: live event with live_on=0 ignored (no output change).
REQ-020 LIVE: live event with live_on=1 -> drive tuple, ch_trig=1, stay LIVE.
REQ-021 LIVE: live event with live_on=0 -> drive tuple (ch_on=0), ch_trig=1, go IDLE.
REQ-022 GAP: counter increments from 0 each en cycle; at GAP_CYCLES-1 -> IDLE, counter cleared.
REQ-023 GAP: live event with live_on=1 preempts -> drive live tuple, ch_trig=1, owner=0, go LIVE, counter cleared.
REQ-024 Echo events in any state are pushed to the queue tail (all four fields, including echo_on=0 events), never driven directly.
REQ-025 Push when full with no pop same cycle -> entry discarded, echo_drop=1, q_count unchanged.
REQ-026 Push and pop same cycle -> both occur, q_count unchanged, no drop, even when full.
REQ-027 Queue order strictly FIFO; pointers are 2-bit and wrap 3->0.
REQ-028 Latency: input change sampled at edge n appears on ch_* with ch_trig at edge n+1 (live) or when popped (echo); pop drives output at the same edge it leaves the queue.
REQ-029 Simultaneous live on-event and non-empty queue in IDLE: live wins, no pop.
REQ-030 ch_* hold last driven value between triggers.

Reset
REQ-031 On reset: state IDLE, GAP counter 0, queue empty, q_count=0, all ch_* 0, ch_trig=0, owner=0, echo_drop=0, both previous-copy registers 0.
REQ-032 Reset overrides en and takes effect mid-operation in any state; queued entries are lost.
REQ-033 After reset, any non-zero input tuple is treated as an event.

Verification
REQ-034 Reset, en=1, live_on=1 note 60 vel 100 pb 256 -> next cycle ch_on=1, ch_note=60, ch_vel=100, ch_pb=256, ch_trig=1, owner=0.
REQ-035 In LIVE, push echo note 60 vel 50 then echo off -> q_count=2, ch_* unchanged; live_on=0 -> ch_on=0 trig; next cycle pop echo 60/50, owner=1; after 16 cycles pop echo-off, q_count=0.
REQ-036 In LIVE, five distinct echo events -> q_count=4, fifth cycle echo_drop=1; drained order equals first four pushes.
REQ-037 In GAP at counter 5, live_on=1 note 72 -> next cycle ch_note=72, owner=0, ch_trig=1, queue untouched.
REQ-038 Queue full in IDLE with echo event on pop cycle -> pop head, push tail, q_count stays 4, echo_drop=0.
REQ-039 en=0 for 10 cycles while live note changes 60->64 -> outputs hold, ch_trig=0; en=1 -> one cycle later ch_note=64, ch_trig=1.
